pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: supervised bring-up for a Gowin PLL in the reference-clock
// domain. It pulses PLL reset, waits for a debounced lock, and then enables the
// NUM_CLK output clock gates one at a time. It also recovers from lock loss,
// retries a lock that times out, and raises fault after MAX_RETRY failed attempts.
// Optional feature macro: PLL_LOCK_LOSS_CNT_EN adds an 8-bit saturating
// lock_loss_cnt output.
module pll_lock_sequencer #(
    parameter int NUM_CLK      = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 256,
    parameter int STAGE_GAP    = 8,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clkin,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic               relock_req,
    output logic               pll_reset,
    output logic [NUM_CLK-1:0] enclk,
    output logic               ready,
    output logic               fault,
    output logic [3:0]         retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]         lock_loss_cnt
`endif
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAX_CD  = (STAGE_GAP > LOCK_TIMEOUT) ? STAGE_GAP : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);
    localparam int STG_W   = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STG_W-1:0]   STG_ONE   = STG_W'(1);
    localparam logic [STG_W-1:0]   STG_LAST  = STG_W'(NUM_CLK - 1);
    localparam logic [NUM_CLK-1:0] EN_ONE    = NUM_CLK'(1);
    localparam logic [3:0]         RETRY_LIM = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        ENABLE,
        RUN,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [NUM_CLK-1:0] enclk_q, enclk_d;
    logic               pll_reset_q, pll_reset_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic [3:0]         retry_q, retry_d;
    logic               lock_p0, lock_p1;
    logic               lock_s;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            lock_p0 <= pll_lock;
            lock_p1 <= lock_p0;
        end
    end

    assign lock_s = lock_p1;

    // State, counters and registered outputs
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            stage_q     <= '0;
            enclk_q     <= '0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            enclk_q     <= enclk_d;
            pll_reset_q <= pll_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            retry_q     <= retry_d;
        end
    end

    // Next-state and next-output decode; relock_req outranks lock loss
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        enclk_d     = enclk_q;
        pll_reset_d = pll_reset_q;
        ready_d     = ready_q;
        fault_d     = fault_q;
        retry_d     = retry_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d     = WAIT_LOCK;
                    cnt_d       = '0;
                    pll_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    retry_d     = retry_q + 4'd1;
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                    if (retry_q + 4'd1 == RETRY_LIM) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = RESET_PLL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = ENABLE;
                    cnt_d   = '0;
                    stage_d = '0;
                    enclk_d = EN_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ENABLE, RUN: begin
                if (relock_req || !lock_s) begin
                    state_d     = RESET_PLL;
                    cnt_d       = '0;
                    stage_d     = '0;
                    enclk_d     = '0;
                    ready_d     = 1'b0;
                    pll_reset_d = 1'b1;
                    if (relock_req) begin
                        retry_d = 4'd0;
                        fault_d = 1'b0;
                    end
                end else if (state_q == ENABLE) begin
                    if (stage_q == STG_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                        retry_d = 4'd0;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        stage_d = stage_q + STG_ONE;
                        enclk_d = enclk_q | (EN_ONE << stage_d);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            FAULT: begin
                if (relock_req) begin
                    state_d     = RESET_PLL;
                    cnt_d       = '0;
                    fault_d     = 1'b0;
                    retry_d     = 4'd0;
                    pll_reset_d = 1'b1;
                end
            end
            default: begin
                state_d     = RESET_PLL;
                cnt_d       = '0;
                stage_d     = '0;
                enclk_d     = '0;
                ready_d     = 1'b0;
                fault_d     = 1'b0;
                pll_reset_d = 1'b1;
            end
        endcase
    end

    assign pll_reset = pll_reset_q;
    assign enclk     = enclk_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    // A drop-out during STABLE, or a lock loss that restarts ENABLE/RUN, is one
    // event. A relock_req on the same cycle takes precedence, so it is not counted.
    assign loss_evt = !lock_s &&
                      ((state_q == STABLE) ||
                       (((state_q == ENABLE) || (state_q == RUN)) && !relock_req));

    // Saturating event counter, cleared only by reset_n
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= 8'd0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed testbench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    localparam int NUM_CLK      = 3;
    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int STAGE_GAP    = 2;
    localparam int LOCK_TIMEOUT = 32;
    localparam int MAX_RETRY    = 3;

    logic               clkin = 1'b0;
    logic               reset_n;
    logic               pll_lock;
    logic               relock_req;
    logic               pll_reset;
    logic [NUM_CLK-1:0] enclk;
    logic               ready;
    logic               fault;
    logic [3:0]         retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0]         lock_loss_cnt;
`endif

    int asserts = 0;
    int fails   = 0;

    pll_lock_sequencer #(
        .NUM_CLK(NUM_CLK),
        .RST_CYCLES(RST_CYCLES),
        .LOCK_STABLE(LOCK_STABLE),
        .STAGE_GAP(STAGE_GAP),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clkin(clkin),
        .reset_n(reset_n),
        .pll_lock(pll_lock),
        .relock_req(relock_req),
        .pll_reset(pll_reset),
        .enclk(enclk),
        .ready(ready),
        .fault(fault),
        .retry_cnt(retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 clkin = ~clkin;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic apply_reset;
        reset_n    = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        asserts++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
        end
    endtask

    task automatic bring_up;
        apply_reset();
        tick(4);
        pll_lock = 1'b1;
        wait_ready(40);
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        tick(2);
        asserts++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL reset_pll_reset: got %b required 1", pll_reset); end
        asserts++; if (enclk !== 3'b000) begin fails++; $display("FAIL reset_enclk: got %b required 000", enclk); end
        asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b required 0", ready); end
        asserts++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b required 0", fault); end
        asserts++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL reset_retry: got %0d required 0", retry_cnt); end
    endtask

    task automatic test_bring_up;
        logic [2:0] exp_en;
        logic       exp_rdy;
        apply_reset();
        for (int i = 0; i <= 4; i++) begin
            asserts++;
            if (pll_reset !== (i < 4)) begin
                fails++;
                $display("FAIL bringup_pll_reset[%0d]: got %b required %b", i, pll_reset, (i < 4));
            end
            if (i < 4) tick(1);
        end
        tick(6);
        pll_lock = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick(1);
            exp_en  = (t < 11) ? 3'b000 : (t < 13) ? 3'b001 : (t < 15) ? 3'b011 : 3'b111;
            exp_rdy = (t >= 16);
            asserts++;
            if (enclk !== exp_en) begin
                fails++;
                $display("FAIL bringup_enclk[t=%0d]: got %b required %b", t, enclk, exp_en);
            end
            asserts++;
            if (ready !== exp_rdy) begin
                fails++;
                $display("FAIL bringup_ready[t=%0d]: got %b required %b", t, ready, exp_rdy);
            end
        end
        asserts++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL bringup_retry: got %0d required 0", retry_cnt); end
        asserts++; if (pll_reset !== 1'b0) begin fails++; $display("FAIL bringup_pll_reset_run: got %b required 0", pll_reset); end
    endtask

    task automatic test_glitchy_lock;
        int         first;
        logic [2:0] seen;
        first = -1;
        seen  = 3'b000;
        apply_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        for (int t = 7; t <= 30; t++) begin
            tick(1);
            if (first < 0 && enclk !== 3'b000) begin
                first = t;
                seen  = enclk;
            end
        end
        asserts++; if (first != 17) begin fails++; $display("FAIL glitch_first_enable: got cycle %0d required 17", first); end
        asserts++; if (seen !== 3'b001) begin fails++; $display("FAIL glitch_first_enclk: got %b required 001", seen); end
        asserts++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL glitch_retry: got %0d required 0", retry_cnt); end
    endtask

    task automatic test_timeout_fault;
        int n;
        apply_reset();
        tick(4);
        for (int a = 1; a <= 3; a++) begin
            n = 0;
            while (pll_reset === 1'b0 && n < 200) begin n++; tick(1); end
            asserts++; if (n != 32) begin fails++; $display("FAIL timeout_wait[%0d]: got %0d cycles required 32", a, n); end
            asserts++; if (retry_cnt !== 4'(a)) begin fails++; $display("FAIL timeout_retry[%0d]: got %0d required %0d", a, retry_cnt, a); end
            if (a < 3) begin
                n = 0;
                while (pll_reset === 1'b1 && n < 200) begin n++; tick(1); end
                asserts++; if (n != 4) begin fails++; $display("FAIL timeout_pulse[%0d]: got %0d cycles required 4", a, n); end
            end
        end
        asserts++; if (fault !== 1'b1) begin fails++; $display("FAIL fault_set: got %b required 1", fault); end
        asserts++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL fault_pll_reset: got %b required 1", pll_reset); end
        tick(10);
        asserts++; if (fault !== 1'b1) begin fails++; $display("FAIL fault_hold: got %b required 1", fault); end
        asserts++; if (enclk !== 3'b000) begin fails++; $display("FAIL fault_enclk: got %b required 000", enclk); end
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        asserts++; if (fault !== 1'b0) begin fails++; $display("FAIL relock_fault: got %b required 0", fault); end
        asserts++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL relock_retry: got %0d required 0", retry_cnt); end
        n = 0;
        while (pll_reset === 1'b1 && n < 200) begin n++; tick(1); end
        asserts++; if (n != 4) begin fails++; $display("FAIL relock_pulse: got %0d cycles required 4", n); end
    endtask

    task automatic test_lock_loss_run;
        int n;
        bring_up();
        pll_lock = 1'b0;
        tick(2);
        asserts++; if (ready !== 1'b1) begin fails++; $display("FAIL loss_sync_delay: ready=%b required 1", ready); end
        tick(1);
        asserts++; if (enclk !== 3'b000) begin fails++; $display("FAIL loss_enclk: got %b required 000", enclk); end
        asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL loss_ready: got %b required 0", ready); end
        n = 0;
        while (pll_reset === 1'b1 && n < 200) begin n++; tick(1); end
        asserts++; if (n != 4) begin fails++; $display("FAIL loss_pulse: got %0d cycles required 4", n); end
        pll_lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 60) begin n++; tick(1); end
        asserts++; if (n != 16) begin fails++; $display("FAIL loss_rebringup: ready after %0d cycles required 16", n); end
        asserts++; if (enclk !== 3'b111) begin fails++; $display("FAIL loss_reenclk: got %b required 111", enclk); end
        asserts++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL loss_retry: got %0d required 0", retry_cnt); end
    endtask

    task automatic test_simultaneous;
        int n;
        bring_up();
        pll_lock = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        asserts++; if (enclk !== 3'b000 || ready !== 1'b0) begin fails++; $display("FAIL simul_outputs: enclk=%b ready=%b required 000/0", enclk, ready); end
        asserts++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL simul_pll_reset: got %b required 1", pll_reset); end
        asserts++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL simul_retry: got %0d required 0", retry_cnt); end
        n = 0;
        while (pll_reset === 1'b1 && n < 200) begin n++; tick(1); end
        asserts++; if (n != 4) begin fails++; $display("FAIL simul_pulse: got %0d cycles required 4", n); end
        n = 0;
        while (pll_reset === 1'b0 && n < 200) begin n++; tick(1); end
        asserts++; if (n != 32) begin fails++; $display("FAIL simul_single_restart: got %0d cycles required 32", n); end
        asserts++; if (retry_cnt !== 4'd1) begin fails++; $display("FAIL simul_retry_after: got %0d required 1", retry_cnt); end
    endtask

    task automatic test_reset_mid_enable;
        apply_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(11);
        asserts++; if (enclk !== 3'b001) begin fails++; $display("FAIL midenable_enclk: got %b required 001", enclk); end
        tick(1);
        #2;
        reset_n = 1'b0;
        #1;
        asserts++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL async_pll_reset: got %b required 1", pll_reset); end
        asserts++; if (enclk !== 3'b000) begin fails++; $display("FAIL async_enclk: got %b required 000", enclk); end
        asserts++; if (ready !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL async_ready_fault: got %b/%b required 0/0", ready, fault); end
        asserts++; if (retry_cnt !== 4'd0) begin fails++; $display("FAIL async_retry: got %0d required 0", retry_cnt); end
    endtask

`ifdef PLL_LOCK_LOSS_CNT_EN
    task automatic test_lock_loss_cnt;
        apply_reset();
        asserts++; if (lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL losscnt_reset: got %0d required 0", lock_loss_cnt); end
        tick(4);
        for (int p = 0; p < 100; p++) begin
            pll_lock = 1'b1;
            tick(3);
            pll_lock = 1'b0;
            tick(3);
        end
        tick(4);
        asserts++; if (lock_loss_cnt !== 8'd100) begin fails++; $display("FAIL losscnt_100: got %0d required 100", lock_loss_cnt); end
        for (int p = 0; p < 200; p++) begin
            pll_lock = 1'b1;
            tick(3);
            pll_lock = 1'b0;
            tick(3);
        end
        tick(4);
        asserts++; if (lock_loss_cnt !== 8'd255) begin fails++; $display("FAIL losscnt_sat: got %0d required 255", lock_loss_cnt); end
        pll_lock = 1'b1;
        wait_ready(60);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        asserts++; if (lock_loss_cnt !== 8'd255) begin fails++; $display("FAIL losscnt_relock: got %0d required 255", lock_loss_cnt); end
        asserts++; if (ready !== 1'b0) begin fails++; $display("FAIL losscnt_relock_ready: got %b required 0", ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_bring_up();
        test_glitchy_lock();
        test_timeout_fault();
        test_lock_loss_run();
        test_simultaneous();
        test_reset_mid_enable();
`ifdef PLL_LOCK_LOSS_CNT_EN
        test_lock_loss_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
